// File: rtl/hamming_dist_acc_if.sv
// Handshake and result bundle for the Hamming-distance accumulator.
// Master drives operands and control; slave returns status and totals.
interface hamming_dist_acc_if #(
  parameter int N  = 32,
  parameter int W  = 16,
  parameter int CW = 16
);
  logic          start;
  logic          in_valid;
  logic          in_last;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          in_ready;
  logic [W-1:0]  sum;
  logic [CW-1:0] words;
  logic          ovf;
  logic          done;

  modport master (
    output start, in_valid, in_last, a, b,
    input  in_ready, sum, words, ovf, done
  );

  modport slave (
    input  start, in_valid, in_last, a, b,
    output in_ready, sum, words, ovf, done
  );
endinterface

// File: rtl/hamming_dist_acc.sv
// Streaming Hamming-distance accumulator: registered popcount of a^b
// feeding a saturating sum, with word count and sticky overflow.
module hamming_dist_acc #(
  parameter int N  = 32,
  parameter int W  = 16,
  parameter int CW = 16
) (
  input logic clk,
  input logic rst,
  hamming_dist_acc_if.slave bus
);

  localparam int K = $clog2(N + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]   state;
  logic [K-1:0] pc;
  logic         pv;
  logic [K-1:0] pc_nx;
  logic [N-1:0] diff;
  logic [W:0]   sum_ext;
  logic [W-1:0] sum_q;
  logic [CW-1:0] words_q;
  logic         ovf_q;
  logic         accept;
  logic         clear;

  assign accept = bus.in_valid && (state == S_RUN);
  assign clear  = bus.start &&
                  ((state == S_IDLE) || (state == S_DONE));
  assign diff   = bus.a ^ bus.b;

  // Population count of the differing bits.
  always_comb begin
    pc_nx = '0;
    for (int i = 0; i < N; i++) begin
      pc_nx = pc_nx + K'(diff[i]);
    end
  end

  // One bit wider than the accumulator so overflow is seen directly.
  assign sum_ext = {1'b0, sum_q} + {{(W + 1 - K){1'b0}}, pc};

  // Run control: a run ends only after an accepted last word drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (bus.start) state <= S_RUN;
        S_RUN:   if (accept && bus.in_last) state <= S_DRAIN;
        S_DRAIN: state <= S_DONE;
        S_DONE:  state <= bus.start ? S_RUN : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage 1: register the popcount of each accepted pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
      pv <= 1'b0;
    end else begin
      pv <= accept;
      if (accept) pc <= pc_nx;
    end
  end

  // Stage 2: saturating accumulate with sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (clear) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (pv) begin
      if (sum_ext[W]) begin
        sum_q <= '1;
        ovf_q <= 1'b1;
      end else begin
        sum_q <= sum_ext[W-1:0];
      end
    end
  end

  // Accepted-word counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_q <= '0;
    end else if (clear) begin
      words_q <= '0;
    end else if (accept) begin
      words_q <= words_q + 1'b1;
    end
  end

  assign bus.in_ready = (state == S_RUN);
  assign bus.done     = (state == S_DONE);
  assign bus.sum      = sum_q;
  assign bus.words    = words_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_hamming_dist_acc.sv
// Randomised scoreboard bench for hamming_dist_acc (N=8, W=8).
// Expected run totals are queued at run start and popped on done.
module tb_hamming_dist_acc;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int CW = 16;

  typedef struct {
    int sum;
    int words;
    int ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hamming_dist_acc_if #(.N(N), .W(W), .CW(CW)) bus ();

  hamming_dist_acc #(.N(N), .W(W), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  res_t exp_q[$];
  logic [N-1:0] qa[$];
  logic [N-1:0] qb[$];
  logic prev_done = 1'b0;
  res_t last_res;

  task automatic chk(input string name, input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference: saturating sum of a monotone series is min(total, max).
  function automatic res_t model();
    res_t r;
    int t;
    t = 0;
    foreach (qa[i]) t += $countones(qa[i] ^ qb[i]);
    r.sum   = (t > (2**W - 1)) ? (2**W - 1) : t;
    r.ovf   = (t > (2**W - 1)) ? 1 : 0;
    r.words = qa.size() % (2**CW);
    return r;
  endfunction

  // Monitor: compare totals whenever done is presented.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_done) chk("done_width", int'(bus.done), 0);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          last_res = e;
          chk("sum", int'(bus.sum), e.sum);
          chk("words", int'(bus.words), e.words);
          chk("ovf", int'(bus.ovf), e.ovf);
        end
      end
      prev_done <= bus.done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap: 0 none, 1 one idle cycle between words, 2 random.
  // Returns in the DONE cycle.
  task automatic do_run(input int gap, input bit noise);
    int n;
    n = qa.size();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ready_after_start", int'(bus.in_ready), 1);
    chk("clr_sum", int'(bus.sum), 0);
    chk("clr_words", int'(bus.words), 0);
    chk("clr_ovf", int'(bus.ovf), 0);
    exp_q.push_back(model());
    for (int i = 0; i < n; i++) begin
      if (i > 0 && (gap == 1 ||
          (gap == 2 && $urandom_range(0, 2) == 0))) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b1;
        bus.start    = noise;
        tick();
      end
      bus.in_valid = 1'b1;
      bus.a        = qa[i];
      bus.b        = qb[i];
      bus.in_last  = (i == n - 1);
      bus.start    = noise;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("drain_not_ready", int'(bus.in_ready), 0);
    chk("drain_no_done", int'(bus.done), 0);
    bus.start = noise;
    tick();
    bus.start = 1'b0;
    chk("done_latency", int'(bus.done), 1);
  endtask

  task automatic push(input int a, input int b);
    qa.push_back(N'(a));
    qb.push_back(N'(b));
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(bus.in_ready), 0);
    chk("rst_sum", int'(bus.sum), 0);
    chk("rst_words", int'(bus.words), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    chk("rst_done", int'(bus.done), 0);
    rst = 1'b0;
    tick();

    // Three mixed words.
    qa.delete(); qb.delete();
    push(8'hFF, 8'h00); push(8'hF0, 8'h0F); push(8'hAA, 8'hAA);
    do_run(0, 1'b0);
    tick();

    // Saturation on word 32 at full throughput.
    qa.delete(); qb.delete();
    for (int i = 0; i < 32; i++) push(8'hFF, 8'h00);
    do_run(0, 1'b0);
    tick();

    // Stray valids while idle, then a gapped run.
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_last  = 1'b1;
      bus.a        = 8'hFF;
      bus.b        = 8'h00;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("idle_words_hold", int'(bus.words), 32);
    chk("idle_ready", int'(bus.in_ready), 0);
    qa.delete(); qb.delete();
    for (int i = 0; i < 3; i++) push(8'h01, 8'h00);
    do_run(1, 1'b0);
    tick();

    // Start noise in RUN/DRAIN, then chained start in DONE.
    qa.delete(); qb.delete();
    push(8'h0F, 8'hF0); push(8'h33, 8'h00);
    do_run(0, 1'b1);
    qa.delete(); qb.delete();
    push(8'h07, 8'h00);
    do_run(0, 1'b0);
    tick();

    // Random runs.
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 40);
      qa.delete(); qb.delete();
      for (int i = 0; i < n; i++)
        push(int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)));
      do_run(2, r[0]);
      if (r[1]) tick();
    end
    tick();

    // Asynchronous abort mid-run.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 8'hFF;
      bus.b        = 8'h00;
      tick();
    end
    chk("pre_abort_words", int'(bus.words), 5);
    #2;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("abort_sum", int'(bus.sum), 0);
    chk("abort_words", int'(bus.words), 0);
    chk("abort_ready", int'(bus.in_ready), 0);
    chk("abort_done", int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("abort_idle", int'(bus.in_ready), 0);
    qa.delete(); qb.delete();
    push(8'h0F, 8'h00);
    do_run(0, 1'b0);
    tick();

    // Single-word run, then results held in IDLE.
    qa.delete(); qb.delete();
    push(8'h81, 8'h7E);
    do_run(0, 1'b0);
    repeat (3) tick();
    chk("hold_sum", int'(bus.sum), 8);
    chk("hold_words", int'(bus.words), 1);
    chk("hold_ready", int'(bus.in_ready), 0);

    repeat (2) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/hamming_dist_acc.md
# hamming_dist_acc

Sequential Hamming-distance accumulator placed directly downstream of the combinational population-count stage. It accepts a stream of operand word pairs and XORs each pair. The XOR word goes through a registered popcount stage, and the resulting per-word counts are summed into a saturating accumulator. The block returns the total distance, the number of accepted words, and a sticky overflow flag, with a one-cycle `done` pulse at the end of each run.

## Interface
- `N`, 32, operand word width in bits (N ≥ 1); popcount width K = clog2(N+1)
- `W`, 16, accumulator width (W ≥ K)
- `CW`, 16, accepted-word counter width
- `clk`  input  1  clock; all state updates on rising edge
- `rst`  input  1  reset; asynchronous, active-high
- `start`  input  1  begin a run; honoured only in IDLE or DONE
- `in_valid`  input  1  `a`/`b`/`in_last` valid this cycle
- `in_last`  input  1  current word pair is the final one of the run
- `a`  input  N  operand word A
- `b`  input  N  operand word B
- `in_ready`  output  1  block accepts a word this cycle (high only in RUN)
- `sum`  output  W  accumulated Hamming distance (registered)
- `words`  output  CW  number of words accepted in the current/last run (registered)
- `ovf`  output  1  sticky: accumulator saturated during this run
- `done`  output  1  one-cycle pulse; run complete, `sum`/`words`/`ovf` final

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
- Reset values: `sum`=0, `words`=0, `ovf`=0, `done`=0, `in_ready`=0; pipeline-valid register cleared.
- IDLE, or DONE with `start`=1: clear `sum`, `words`, `ovf` and go to RUN.
- IDLE with `start`=0: hold all outputs. The previous run's results remain readable.
- DONE with `start`=0: go to IDLE.
- RUN behaviour:
  - `in_ready`=1.
  - Accept on `in_valid`&`in_ready`. Each accept increments `words`; `words` wraps modulo 2^CW.
  - Accept with `in_last`=1 moves the state to DRAIN.
  - `start` is ignored.
- DRAIN: `in_ready`=0. Next edge moves to DONE.
- DONE: `done`=1 for exactly this cycle.
- Stage 1 (popcount register):
  - On accept: pc ← popcount(a ^ b), K bits, range 0..N; pv ← 1.
  - Otherwise pv ← 0.
- Stage 2 (accumulate): when pv=1, sum ← sum + pc computed at W+1 bits.
  - If the result exceeds 2^W−1, sum ← 2^W−1 and ovf ← 1.
  - Once saturated, `sum` stays at 2^W−1 for the rest of the run.
- `in_last` without `in_valid` has no effect. `in_valid` outside RUN is ignored and does not count.
- A run of zero words is impossible: a run ends only on an accepted `in_last`.
- `rst` asserted mid-run aborts immediately (asynchronously) to IDLE with reset values. No `done` is produced.

## Timing
- `start` sampled at edge t moves to RUN after edge t; `in_ready` is high in the cycle after t.
- A word accepted at edge e gives pc/pv valid after e, and `sum` updated after edge e+1. Accumulate latency is 2 edges.
- `words` is updated after edge e (1-edge latency).
- Last word accepted at edge e:
  - DRAIN after e.
  - Final `sum` and DONE after e+1.
  - `done` high for the cycle between e+1 and e+2.
  - `sum` is stable from the cycle `done` rises.
- Back-to-back accepts every cycle in RUN: full throughput, one word/cycle, no bubbles required.
- `start` in the DONE cycle begins a new run with no intervening IDLE cycle; `in_ready` is high the next cycle.
- Saturation takes effect in the same edge as the overflowing add; `ovf` is visible the next cycle.

## Test plan
- N=8, W=8: start; send 3 words (a,b) = (0xFF,0x00), (0xF0,0x0F), (0xAA,0xAA), last on third → `done` pulses 2 edges after the last accept; `sum`=16, `words`=3, `ovf`=0.
- N=8, W=8: 32 words of (0xFF,0x00), in_valid held high, last on word 32 → `sum`=255 (saturated at word 32), `ovf`=1, `words`=32, throughput 1 word/cycle.
- Gaps and stray inputs: in_valid toggled 1,0,1,0,1 with (0x01,0x00) each valid cycle; in_valid pulses while IDLE → `words`=3, `sum`=3; IDLE pulses not counted.
- `start` during RUN and DRAIN → ignored; sum/words unchanged. Then `start` in the DONE cycle → new run, `sum`/`words`/`ovf` cleared, `in_ready`=1 next cycle.
- `rst` asserted asynchronously mid-RUN after 5 words → all outputs 0 immediately, state IDLE, no `done`. After release, a new run of (0x0F,0x00) with last gives `sum`=4, `words`=1.
- Single-word run: start, one accept (0x81,0x7E) with `in_last` → `sum`=8, `words`=1, `done` pulse exactly 1 cycle, then IDLE holding results.
